fwd_hazard_scoreboard: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined RISC core. It keeps an internal shift register of in-flight writers, so the downstream stages do not have to feed back their rd and write-enable signals. Each cycle it resolves forward-select codes for NUM_SRC source operands of the instruction in RR/EX. It also generates a load-use stall whose depth is set by LOAD_LAT, and keeps a saturating stall-cycle counter.

---
 rtl/fwd_hazard_scoreboard_pkg.sv | 18 +
 rtl/fwd_src_resolver.sv | 32 +++
 rtl/fwd_hazard_scoreboard.sv | 100 ++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared constants and entry layout for the forwarding / load-use hazard scoreboard.
// Opcodes, forward-select codes and the per-entry flag record live here.
package fwd_hazard_scoreboard_pkg;

   localparam logic [3:0] OP_ALU    = 4'b0000;
   localparam logic [3:0] OP_LOAD   = 4'b0100;
   localparam logic [3:0] OP_STORE  = 4'b0101;
   localparam logic [3:0] OP_BRANCH = 4'b1000;

   // Select code 0 always means "read the register file"; k means "forward from entry k".
   localparam int unsigned FWD_RF = 0;

   typedef struct packed {
      logic v;
      logic ld;
   } ent_flags_t;

endpackage

// File: rtl/fwd_src_resolver.sv
// Priority match of one source operand against all in-flight writers.
// The youngest matching entry wins; load_hit flags a load that is still too young to forward.
module fwd_src_resolver
   import fwd_hazard_scoreboard_pkg::*;
#(
   parameter int AW        = 3,
   parameter int FWD_DEPTH = 3,
   parameter int LOAD_LAT  = 1,
   parameter int SEL_W     = 2
) (
   input  logic [AW-1:0]           src_addr,
   input  logic                    src_used,
   input  logic [FWD_DEPTH-1:0]    ent_v,
   input  logic [FWD_DEPTH-1:0]    ent_ld,
   input  logic [FWD_DEPTH*AW-1:0] ent_rd,
   output logic [SEL_W-1:0]        sel,
   output logic                    load_hit
);

   always_comb begin
      sel      = SEL_W'(FWD_RF);
      load_hit = 1'b0;
      // Oldest to youngest, so the last hit left standing is the youngest writer.
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (src_used && ent_v[k-1] && (ent_rd[(k-1)*AW +: AW] == src_addr)) begin
            sel      = SEL_W'(k);
            load_hit = ent_ld[k-1] && (k <= LOAD_LAT);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight writers in a private shift register,
// resolves per-operand forward selects and raises a load-use stall with a saturating counter.
module fwd_hazard_scoreboard
   import fwd_hazard_scoreboard_pkg::*;
#(
   parameter int             AW        = 3,
   parameter int             NUM_SRC   = 2,
   parameter int             FWD_DEPTH = 3,
   parameter int             LOAD_LAT  = 1,
   parameter int             OPW       = 4,
   parameter logic [OPW-1:0] LOAD_OP   = OPW'(OP_LOAD),
   parameter int             SEL_W     = $clog2(FWD_DEPTH + 1),
   parameter int             CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     hold,
   input  logic                     flush,
   input  logic                     issue_valid,
   input  logic                     issue_wr_en,
   input  logic [AW-1:0]            issue_rd,
   input  logic [OPW-1:0]           issue_opcode,
   input  logic [NUM_SRC*AW-1:0]    src_addr,
   input  logic [NUM_SRC-1:0]       src_used,
   input  logic                     cnt_clr,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     stall_load,
   output logic [CNT_W-1:0]         stall_count
);

   // Index k-1 holds entry k (entry 1 = youngest, EX/MEM).
   ent_flags_t [FWD_DEPTH-1:0] flags_q, flags_d;
   logic [FWD_DEPTH*AW-1:0]    rd_q, rd_d;
   logic [FWD_DEPTH-1:0]       ent_v, ent_ld;
   logic [NUM_SRC-1:0]         load_hit;
   logic [CNT_W-1:0]           cnt_d;

   always_comb begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
         ent_v[k]  = flags_q[k].v;
         ent_ld[k] = flags_q[k].ld;
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_resolver #(
         .AW        (AW),
         .FWD_DEPTH (FWD_DEPTH),
         .LOAD_LAT  (LOAD_LAT),
         .SEL_W     (SEL_W)
      ) u_resolver (
         .src_addr (src_addr[i*AW +: AW]),
         .src_used (src_used[i]),
         .ent_v    (ent_v),
         .ent_ld   (ent_ld),
         .ent_rd   (rd_q),
         .sel      (fwd_sel[i*SEL_W +: SEL_W]),
         .load_hit (load_hit[i])
      );
   end

   // Flush dominates: a squashed instruction can neither stall nor occupy an entry.
   assign stall_load = issue_valid & ~flush & (|load_hit);

   always_comb begin
      flags_d = flags_q;
      rd_d    = rd_q;
      if (!hold) begin
         for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
            flags_d[k]            = flags_q[k-1];
            rd_d[k*AW +: AW]      = rd_q[(k-1)*AW +: AW];
         end
         flags_d[0].v  = issue_valid & issue_wr_en & ~flush & ~stall_load;
         flags_d[0].ld = (issue_opcode == LOAD_OP);
         rd_d[AW-1:0]  = issue_rd;
      end
   end

   always_comb begin
      cnt_d = stall_count;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (stall_load && !hold && !(&stall_count)) begin
         cnt_d = stall_count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q     <= '0;
         rd_q        <= '0;
         stall_count <= '0;
      end else begin
         flags_q     <= flags_d;
         rd_q        <= rd_d;
         stall_count <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench: the driver queues hand-computed expectations, a negedge monitor checks them.
// dut_a uses the default configuration; dut_b is the deep variant with a narrow counter.
module tb_fwd_hazard_scoreboard;

   localparam logic [3:0] ADD = 4'b0000;
   localparam logic [3:0] LD  = 4'b0100;

   logic        clk = 1'b0;
   logic        reset, hold, flush, issue_valid, issue_wr_en, cnt_clr;
   logic [3:0]  issue_rd, issue_opcode;
   logic [5:0]  src_a;
   logic [1:0]  used_a;
   logic [11:0] src_b;
   logic [2:0]  used_b;
   logic [3:0]  fwd_sel_a;
   logic [8:0]  fwd_sel_b;
   logic        stall_a, stall_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   always #5 clk = ~clk;

   fwd_hazard_scoreboard dut_a (
      .clk          (clk),
      .reset        (reset),
      .hold         (hold),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_wr_en  (issue_wr_en),
      .issue_rd     (issue_rd[2:0]),
      .issue_opcode (issue_opcode),
      .src_addr     (src_a),
      .src_used     (used_a),
      .cnt_clr      (cnt_clr),
      .fwd_sel      (fwd_sel_a),
      .stall_load   (stall_a),
      .stall_count  (cnt_a)
   );

   fwd_hazard_scoreboard #(
      .AW        (4),
      .NUM_SRC   (3),
      .FWD_DEPTH (4),
      .LOAD_LAT  (2),
      .CNT_W     (4)
   ) dut_b (
      .clk          (clk),
      .reset        (reset),
      .hold         (hold),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_wr_en  (issue_wr_en),
      .issue_rd     (issue_rd),
      .issue_opcode (issue_opcode),
      .src_addr     (src_b),
      .src_used     (used_b),
      .cnt_clr      (cnt_clr),
      .fwd_sel      (fwd_sel_b),
      .stall_load   (stall_b),
      .stall_count  (cnt_b)
   );

   typedef struct {
      string       name;
      int          which;
      logic [15:0] sel;
      logic        st;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;
   logic [15:0] act_sel, act_cnt;
   logic        act_st;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e       = q.pop_front();
         act_sel = (e.which == 0) ? 16'(fwd_sel_a) : 16'(fwd_sel_b);
         act_st  = (e.which == 0) ? stall_a : stall_b;
         act_cnt = (e.which == 0) ? cnt_a : 16'(cnt_b);
         checks++;
         if (act_sel !== e.sel || act_st !== e.st || act_cnt !== e.cnt) begin
            failures++;
            $display("FAIL %s: got sel=%h stall=%b cnt=%h, want sel=%h stall=%b cnt=%h",
                     e.name, act_sel, act_st, act_cnt, e.sel, e.st, e.cnt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string n, input int wh, input logic [15:0] s,
                             input logic st, input logic [15:0] c);
      exp_t x;
      x.name  = n;
      x.which = wh;
      x.sel   = s;
      x.st    = st;
      x.cnt   = c;
      q.push_back(x);
   endtask

   task automatic da(input logic v, input logic w, input logic [3:0] rd, input logic [3:0] op,
                     input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] u);
      issue_valid  = v;
      issue_wr_en  = w;
      issue_rd     = rd;
      issue_opcode = op;
      src_a        = {s1, s0};
      used_a       = u;
   endtask

   task automatic db(input logic v, input logic w, input logic [3:0] rd, input logic [3:0] op,
                     input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [2:0] u);
      issue_valid  = v;
      issue_wr_en  = w;
      issue_rd     = rd;
      issue_opcode = op;
      src_b        = {s2, s1, s0};
      used_b       = u;
   endtask

   initial begin
      // Reset with every input active.
      reset = 1'b1; hold = 1'b1; flush = 1'b1; cnt_clr = 1'b1;
      da(1, 1, 4'd3, LD, 3'd3, 3'd3, 2'b11);
      src_b = {4'd3, 4'd3, 4'd3}; used_b = 3'b111;
      tick(); expect_out("rst_a", 0, 16'h0, 0, 16'd0);
      tick(); expect_out("rst_b", 1, 16'h0, 0, 16'd0);
      tick();
      reset = 1'b0; hold = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
      src_b = '0; used_b = '0;
      da(1, 1, 4'd3, ADD, 0, 0, 2'b00);      expect_out("fwd_none", 0, 16'h0, 0, 16'd0);
      tick(); da(0, 0, 0, ADD, 3'd3, 0, 2'b01); expect_out("fwd_e1", 0, 16'h1, 0, 16'd0);
      tick(); expect_out("fwd_e2", 0, 16'h2, 0, 16'd0);
      tick(); expect_out("fwd_e3", 0, 16'h3, 0, 16'd0);
      tick(); expect_out("fwd_gone", 0, 16'h0, 0, 16'd0);

      // Load-use with LOAD_LAT=1: one stall cycle, then forward from entry 2.
      tick(); da(1, 1, 4'd5, LD, 0, 0, 2'b00);      expect_out("ld_issue", 0, 16'h0, 0, 16'd0);
      tick(); da(1, 1, 4'd6, ADD, 0, 3'd5, 2'b10);  expect_out("ld_stall", 0, 16'h4, 1, 16'd0);
      tick(); expect_out("ld_fwd_e2", 0, 16'h8, 0, 16'd1);
      tick(); da(0, 0, 0, ADD, 0, 0, 2'b00);        expect_out("ld_idle", 0, 16'h0, 0, 16'd1);
      repeat (4) tick();

      // Younger ADD shadows an older load to the same register.
      tick(); da(1, 1, 4'd2, LD, 0, 0, 2'b00);
      tick(); da(1, 1, 4'd2, ADD, 0, 0, 2'b00);
      tick(); da(1, 0, 0, ADD, 3'd2, 3'd2, 2'b11);  expect_out("youngest_wins", 0, 16'h5, 0, 16'd1);
      tick(); da(0, 0, 0, ADD, 3'd2, 3'd2, 2'b00);  expect_out("src_unused", 0, 16'h0, 0, 16'd1);
      tick(); da(1, 0, 4'd4, ADD, 0, 0, 2'b00);
      tick(); da(0, 0, 0, ADD, 3'd4, 0, 2'b01);     expect_out("no_wr_en", 0, 16'h0, 0, 16'd1);
      tick(); da(0, 0, 0, ADD, 0, 0, 2'b00);
      repeat (3) tick();

      // Flush beats the load-use stall and leaves a bubble.
      tick(); da(1, 1, 4'd7, LD, 0, 0, 2'b00);
      tick(); da(1, 1, 4'd1, ADD, 3'd7, 0, 2'b01); flush = 1'b1;
      expect_out("flush_stall", 0, 16'h1, 0, 16'd1);
      tick(); flush = 1'b0; da(0, 0, 0, ADD, 3'd1, 0, 2'b01);
      expect_out("flush_bubble", 0, 16'h0, 0, 16'd1);
      tick(); da(0, 0, 0, ADD, 0, 0, 2'b00);
      repeat (3) tick();

      // Hold freezes entries and the counter while a stall is pending.
      tick(); da(1, 1, 4'd3, LD, 0, 0, 2'b00);
      tick(); hold = 1'b1; da(1, 0, 0, ADD, 3'd3, 0, 2'b01);
      expect_out("hold_0", 0, 16'h1, 1, 16'd1);
      tick(); expect_out("hold_1", 0, 16'h1, 1, 16'd1);
      tick(); expect_out("hold_2", 0, 16'h1, 1, 16'd1);
      tick(); hold = 1'b0; expect_out("hold_release", 0, 16'h1, 1, 16'd1);
      tick(); expect_out("after_hold", 0, 16'h2, 0, 16'd2);

      // cnt_clr wins over a simultaneous increment.
      tick(); da(1, 1, 4'd6, LD, 0, 0, 2'b00);
      tick(); da(1, 0, 0, ADD, 3'd6, 0, 2'b01); cnt_clr = 1'b1;
      expect_out("clr_prio", 0, 16'h1, 1, 16'd2);
      tick(); cnt_clr = 1'b0; da(0, 0, 0, ADD, 3'd6, 0, 2'b01);
      expect_out("clr_done", 0, 16'h2, 0, 16'd0);

      // Reset raised between edges with a load-use pending must drop the stall at once.
      tick(); da(1, 1, 4'd1, LD, 0, 0, 2'b00);
      tick(); da(1, 0, 0, ADD, 3'd1, 0, 2'b01); reset = 1'b1;
      expect_out("async_reset", 0, 16'h0, 0, 16'd0);
      tick(); reset = 1'b0; da(0, 0, 0, ADD, 0, 0, 2'b00);

      // Deep variant: LOAD_LAT=2 gives two stall cycles, then forward from entry 3.
      tick(); db(1, 1, 4'd9, LD, 0, 0, 0, 3'b000);         expect_out("b_idle", 1, 16'h000, 0, 16'd0);
      tick(); db(1, 1, 4'd10, ADD, 0, 0, 4'd9, 3'b100);    expect_out("b_stall1", 1, 16'h040, 1, 16'd0);
      tick(); expect_out("b_stall2", 1, 16'h080, 1, 16'd1);
      tick(); expect_out("b_fwd_e3", 1, 16'h0C0, 0, 16'd2);
      tick(); db(0, 0, 0, ADD, 4'd10, 0, 4'd9, 3'b101);    expect_out("b_fwd_e4", 1, 16'h101, 0, 16'd2);

      // Two stalls per three cycles: 16 more stalls drive the 4-bit counter into saturation.
      for (int n = 0; n < 8; n++) begin
         tick(); db(1, 1, 4'd1, LD, 0, 0, 0, 3'b000);
         tick(); db(1, 0, 0, ADD, 4'd1, 0, 0, 3'b001);
         tick();
      end
      tick(); db(1, 1, 4'd1, LD, 0, 0, 0, 3'b000);         expect_out("b_sat", 1, 16'h000, 0, 16'd15);
      tick(); db(1, 0, 0, ADD, 4'd1, 0, 0, 3'b001);        expect_out("b_sat_stall", 1, 16'h001, 1, 16'd15);
      tick(); cnt_clr = 1'b1; expect_out("b_sat_nowrap", 1, 16'h002, 1, 16'd15);
      tick(); cnt_clr = 1'b0; expect_out("b_clr", 1, 16'h003, 0, 16'd0);
      tick();
      tick();
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: got %0d pending, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
